// File: rtl/cdm_fetch_pkg.sv
// Shared definitions for the instruction fetch queue.
// Holds the fetch FSM state encoding, the queue entry layout,
// default reset PC / queue depth and the PC alignment helper.
package cdm_fetch_pkg;

   localparam logic [15:0]  RESET_PC_DEFAULT = 16'h0000;
   localparam int unsigned  DEPTH_DEFAULT    = 2;

   // IDLE: nothing outstanding; BUSY: result kept; DISCARD: result dropped
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BUSY    = 2'd1,
      ST_DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] word;
   } fetch_entry_t;

   // Instruction addresses are word aligned; bit 0 is forced low.
   function automatic logic [15:0] align_pc(input logic [15:0] pc);
      return pc & 16'hFFFE;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, word} entries for the decoder.
// Entry 0 is always the head, so head outputs come straight from flops.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   push, wr_pc/wr_word append an entry
//   pop                 drop the head entry
//   flush               empty the queue (overrides push and pop)
//   head_valid          queue not empty (registered)
//   head_pc/head_word   head entry
//   count               number of valid entries
module fetch_fifo
   import cdm_fetch_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  logic [15:0]                  wr_pc,
   input  logic [15:0]                  wr_word,
   output logic                         head_valid,
   output logic [15:0]                  head_pc,
   output logic [15:0]                  head_word,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_entry_t   ent_q [DEPTH];
   fetch_entry_t   ent_d [DEPTH];
   logic [CW-1:0]  count_q;
   logic [CW-1:0]  count_d;
   logic [CW-1:0]  wr_idx;
   logic           valid_q;

   // Shift on pop, then write the new entry just behind the last survivor.
   always_comb begin
      ent_d   = ent_q;
      count_d = count_q;
      wr_idx  = pop ? (count_q - CW'(1)) : count_q;
      if (flush) begin
         count_d = '0;
      end else begin
         if (pop) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
               ent_d[i] = ent_q[i + 1];
            end
         end
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (push && (wr_idx == CW'(i))) begin
               ent_d[i] = '{pc: wr_pc, word: wr_word};
            end
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         valid_q <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
         end
      end else begin
         assert (!(push && (count_q == CW'(DEPTH))));
         count_q <= count_d;
         valid_q <= (count_d != '0);
         ent_q   <= ent_d;
      end
   end

   assign head_valid = valid_q;
   assign head_pc    = ent_q[0].pc;
   assign head_word  = ent_q[0].word;
   assign count      = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch unit: issues one memory request at a time, queues
// returned words for the decoder and handles redirects/stalls.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mem_req/mem_addr            outstanding fetch request (held until ack)
//   mem_ack/mem_rdata           memory completion and returned word
//   dec_valid/dec_instruction/dec_pc  queue head presented to the decoder
//   dec_ready                   decoder consumes the head
//   redirect/redirect_pc        flush and restart fetch at a new address
//   fetch_stall                 suppress new requests
module ifetch_queue
   import cdm_fetch_pkg::*;
#(
   parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic        dec_valid,
   output logic [15:0] dec_instruction,
   output logic [15:0] dec_pc,
   input  logic        dec_ready,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   input  logic        fetch_stall
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_state_e   state_q, state_d;
   logic [15:0]    fetch_pc_q, fetch_pc_d;
   logic [15:0]    mem_addr_q, mem_addr_d;
   logic           mem_req_q, mem_req_d;
   logic           push, pop, flush;
   logic           head_valid;
   logic [CW-1:0]  count;

   // State register and request outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         fetch_pc_q <= RESET_PC;
         mem_addr_q <= RESET_PC;
         mem_req_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         mem_addr_q <= mem_addr_d;
         mem_req_q  <= mem_req_d;
      end
   end

   // Next-state, request issue and queue control
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      mem_addr_d = mem_addr_q;
      mem_req_d  = mem_req_q;
      push       = 1'b0;
      flush      = redirect;
      pop        = head_valid && dec_ready && !redirect;
      case (state_q)
         ST_IDLE: begin
            if (redirect) begin
               fetch_pc_d = align_pc(redirect_pc);
            end else if (!fetch_stall && (count < CW'(DEPTH))) begin
               // Only one issue per empty slot, so a push never finds the queue full
               state_d    = ST_BUSY;
               mem_req_d  = 1'b1;
               mem_addr_d = fetch_pc_q;
            end
         end
         ST_BUSY: begin
            if (mem_ack) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
               if (redirect) begin
                  fetch_pc_d = align_pc(redirect_pc);
               end else begin
                  push       = 1'b1;
                  fetch_pc_d = fetch_pc_q + 16'd2;
               end
            end else if (redirect) begin
               state_d    = ST_DISCARD;
               fetch_pc_d = align_pc(redirect_pc);
            end
         end
         ST_DISCARD: begin
            if (redirect) begin
               fetch_pc_d = align_pc(redirect_pc);
            end
            if (mem_ack) begin
               state_d   = ST_IDLE;
               mem_req_d = 1'b0;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .flush      (flush),
      .wr_pc      (mem_addr_q),
      .wr_word    (mem_rdata),
      .head_valid (head_valid),
      .head_pc    (dec_pc),
      .head_word  (dec_instruction),
      .count      (count)
   );

   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign dec_valid = head_valid;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a memory model acks requests after a
// programmable latency and pushes the expected {pc, word}; the decoder side
// pops and compares whenever the head is presented.
module tb_ifetch_queue;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] word;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_req, mem_ack;
   logic [15:0] mem_addr, mem_rdata;
   logic        dec_valid, dec_ready;
   logic [15:0] dec_instruction, dec_pc;
   logic        redirect, fetch_stall;
   logic [15:0] redirect_pc;

   always #5 clk = ~clk;

   ifetch_queue dut (
      .clk             (clk),
      .rst             (rst),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_ack         (mem_ack),
      .mem_rdata       (mem_rdata),
      .dec_valid       (dec_valid),
      .dec_instruction (dec_instruction),
      .dec_pc          (dec_pc),
      .dec_ready       (dec_ready),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .fetch_stall     (fetch_stall)
   );

   exp_t        sb[$];
   logic [15:0] issue_log[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          lat = 0;
   int          lat_cnt = 0;
   int          pops = 0;
   bit          tracking = 0, stale = 0, after_ack = 0;
   bit          dead_next = 0, inject_ack = 0, seen_dead = 0;
   logic [15:0] out_addr = '0;
   logic [15:0] last_pc = '0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] word_of(input logic [15:0] a);
      return a ^ 16'h5A5A;
   endfunction

   // Odd sentinel: never a legal fetch address
   function automatic logic [15:0] log_at(input int i);
      return (i < issue_log.size()) ? issue_log[i] : 16'hFFFF;
   endfunction

   // One clock: check outputs, model memory and decoder, advance the edge.
   task automatic cycle();
      check("addr_bit0", 16'(mem_addr[0]), 16'd0);
      check("dec_valid", 16'(dec_valid), 16'(sb.size() != 0));
      if (sb.size() != 0 && dec_valid) begin
         check("dec_pc", dec_pc, sb[0].pc);
         check("dec_instr", dec_instruction, sb[0].word);
      end
      if (dec_valid && dec_instruction == 16'hDEAD) seen_dead = 1;
      if (after_ack) check("req_gap", 16'(mem_req), 16'd0);
      after_ack = 0;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (mem_req) begin
         if (!tracking) begin
            tracking = 1;
            stale    = 0;
            lat_cnt  = 0;
            out_addr = mem_addr;
            issue_log.push_back(mem_addr);
         end else begin
            check("req_hold", mem_addr, out_addr);
         end
         if (lat_cnt >= lat) begin
            mem_ack   = 1'b1;
            mem_rdata = dead_next ? 16'hDEAD : word_of(out_addr);
            dead_next = 0;
         end
      end else begin
         if (tracking) begin
            check("req_dropped", 16'(mem_req), 16'd1);
            tracking = 0;
         end
         if (inject_ack) begin
            mem_ack   = 1'b1;
            mem_rdata = 16'hBEEF;
         end
      end
      inject_ack = 0;
      if (dec_valid && dec_ready && !redirect && !rst && sb.size() != 0) begin
         last_pc = sb[0].pc;
         void'(sb.pop_front());
         pops++;
      end
      if (mem_ack && tracking && !stale && !redirect && !rst)
         sb.push_back('{pc: out_addr, word: mem_rdata});
      if (mem_ack && tracking) begin
         tracking  = 0;
         after_ack = 1;
      end
      if (redirect || rst) begin
         sb.delete();
         issue_log.delete();
         if (tracking) stale = 1;
      end
      if (rst) begin
         tracking  = 0;
         after_ack = 0;
      end
      @(posedge clk);
      #1;
      if (tracking) lat_cnt++;
   endtask

   // Run until a fresh request appears, bounded.
   task automatic wait_for_req(input int budget);
      int n = 0;
      while (!(mem_req && !tracking) && n < budget) begin
         cycle();
         n++;
      end
      check("req_timeout", 16'(mem_req && !tracking), 16'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_req"},   16'(mem_req),    16'd0);
      check({tag, "_mem_addr"},  mem_addr,        16'h0000);
      check({tag, "_dec_valid"}, 16'(dec_valid),  16'd0);
      check({tag, "_dec_instr"}, dec_instruction, 16'h0000);
      check({tag, "_dec_pc"},    dec_pc,          16'h0000);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; dec_ready = 1'b0;
      redirect = 1'b0; redirect_pc = '0; fetch_stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;

      // Zero-wait memory, decoder always ready: sequential fetch and throughput
      lat = 0; dec_ready = 1'b1;
      repeat (4) cycle();
      pops = 0;
      repeat (10) cycle();
      check("throughput", 16'(pops >= 5), 16'd1);
      check("seq_a0", log_at(0), 16'h0000);
      check("seq_a1", log_at(1), 16'h0002);
      check("seq_a2", log_at(2), 16'h0004);

      // Decoder stalled: queue fills to two, issue stops, then drains in order
      dec_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0100;
      cycle();
      redirect = 1'b0;
      repeat (10) cycle();
      check("full_valid", 16'(dec_valid), 16'd1);
      check("full_head", dec_pc, 16'h0100);
      check("full_noreq", 16'(mem_req), 16'd0);
      check("full_issues", 16'(issue_log.size()), 16'd2);
      check("full_a1", log_at(1), 16'h0102);
      dec_ready = 1'b1; pops = 0;
      repeat (6) cycle();
      check("drain", 16'(pops >= 2), 16'd1);

      // Redirect while BUSY: late DEAD ack is discarded, refetch aligned target
      lat = 3;
      wait_for_req(10);
      dead_next = 1; redirect = 1'b1; redirect_pc = 16'h1235;
      cycle();
      redirect = 1'b0;
      repeat (14) cycle();
      check("redir_addr", log_at(0), 16'h1234);
      check("no_dead", 16'(seen_dead), 16'd0);

      // Redirect coinciding with the ack that would fill the queue
      lat = 0; dec_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'h0300;
      cycle();
      redirect = 1'b0;
      n = 0;
      while (!(sb.size() == 1 && mem_req && !tracking) && n < 20) begin
         cycle();
         n++;
      end
      check("fill_setup", 16'(sb.size() == 1 && mem_req && !tracking), 16'd1);
      dec_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h2000;
      cycle();
      redirect = 1'b0;
      check("flush_valid", 16'(dec_valid), 16'd0);
      check("flush_req", 16'(mem_req), 16'd0);
      repeat (4) cycle();
      check("flush_target", log_at(0), 16'h2000);

      // Address wrap with fetch_stall raised while BUSY
      lat = 2; redirect = 1'b1; redirect_pc = 16'hFFFE;
      cycle();
      redirect = 1'b0;
      wait_for_req(10);
      check("wrap_addr", mem_addr, 16'hFFFE);
      fetch_stall = 1'b1;
      repeat (10) cycle();
      check("stall_issues", 16'(issue_log.size()), 16'd1);
      check("stall_noreq", 16'(mem_req), 16'd0);
      check("wrap_pc", last_pc, 16'hFFFE);
      fetch_stall = 1'b0;
      repeat (6) cycle();
      check("wrap_next", log_at(1), 16'h0000);

      // Four-cycle ack latency with request held, then reset mid-request
      lat = 4; redirect = 1'b1; redirect_pc = 16'h0400;
      cycle();
      redirect = 1'b0;
      wait_for_req(12);
      repeat (7) cycle();
      check("long_word", last_pc, 16'h0400);
      wait_for_req(12);
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check_reset_outputs("midreq_rst");
      inject_ack = 1;
      repeat (5) cycle();
      check("post_rst_addr", log_at(0), 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, fetch address loaded on reset.
REQ-002 Parameter DEPTH, default 2, prefetch queue entries; only DEPTH=2 is required.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 mem_req  out  1  fetch request to instruction memory.
REQ-006 mem_addr  out  16  word address of the outstanding request, bit0 always 0.
REQ-007 mem_ack  in  1  memory returns mem_rdata this cycle, completing the request.
REQ-008 mem_rdata  in  16  fetched instruction word.
REQ-009 dec_valid  out  1  queue head holds a valid instruction for the decoder.
REQ-010 dec_instruction  out  16  queue head word, drives the decoder instruction input.
REQ-011 dec_pc  out  16  address of the queue head word.
REQ-012 dec_ready  in  1  decoder consumes head this cycle.
REQ-013 redirect  in  1  branch/jsr/rti/int/exception taken; flush and refetch.
REQ-014 redirect_pc  in  16  new fetch address; bit0 ignored, forced 0.
REQ-015 fetch_stall  in  1  halt/wait active; no new requests issued.

Function
REQ-016 FSM states: IDLE (no request outstanding), BUSY (request outstanding, result kept), DISCARD (request outstanding, result dropped).
REQ-017 At most one memory request SHALL be outstanding at any time.
REQ-018 IDLE->BUSY when !redirect && !fetch_stall && count < DEPTH; mem_req=1, mem_addr=fetch_pc that same cycle.
REQ-019 mem_req and mem_addr SHALL stay constant from issue until the cycle of mem_ack, in BUSY and DISCARD alike.
REQ-020 BUSY with mem_ack && !redirect: push mem_rdata with pc=mem_addr, fetch_pc += 2 (mod 2^16, 16'hFFFE wraps to 16'h0000), ->IDLE.
REQ-021 Pop when dec_valid && dec_ready; push and pop in the same cycle SHALL both take effect, count unchanged.
REQ-022 Issue condition ensures no push to a full queue; a push with count==DEPTH is an assertion failure.
REQ-023 redirect (any state): queue flushed (count=0, dec_valid=0 next cycle), fetch_pc=redirect_pc&16'hFFFE; any same-cycle pop or push is cancelled.
REQ-024 redirect in BUSY without mem_ack ->DISCARD; redirect with mem_ack in BUSY -> data dropped, ->IDLE.
REQ-025 DISCARD with mem_ack: data dropped, ->IDLE; redirect in DISCARD updates fetch_pc, stays DISCARD unless mem_ack.
REQ-026 First request to the new target SHALL be issued no earlier than the cycle after the redirect or after the discarded ack.
REQ-027 fetch_stall blocks only new issues; an outstanding request completes and is pushed normally.
REQ-028 dec_valid = (count != 0); dec_instruction/dec_pc SHALL be registered queue outputs, stable while dec_valid && !dec_ready && !redirect.
REQ-029 Steady-state throughput: with zero-wait memory (ack in issue cycle) and dec_ready=1, one instruction per two cycles minimum.

Reset
REQ-030 rst: state=IDLE, fetch_pc=RESET_PC, count=0, mem_req=0, mem_addr=RESET_PC, dec_valid=0, dec_instruction=0, dec_pc=0.
REQ-031 rst SHALL override redirect, mem_ack and dec_ready in the same cycle; an ack arriving after rst for a pre-reset request is ignored (mem side also reset).

Structure
REQ-032 Shared package cdm_fetch_pkg holds the FSM state enum, RESET_PC default, and DEPTH default.
REQ-033 Queue implemented as one sub-module fetch_fifo (DEPTH entries of {pc, word}, push/pop/flush, count); FSM and fetch_pc stay in ifetch_queue.

Verification
REQ-034 Reset, mem_ack same-cycle, dec_ready=1 -> mem_addr sequence 0000,0002,0004; dec_pc matches; dec_instruction = mem_rdata per address.
REQ-035 dec_ready=0 for 10 cycles -> exactly 2 words queued, mem_req=0 after second ack, no request issued; then dec_ready=1 drains in order.
REQ-036 Redirect to 16'h1235 while BUSY, ack 3 cycles later with 16'hDEAD -> DEAD never appears on dec_instruction; next mem_addr=16'h1234.
REQ-037 Redirect and mem_ack same cycle with full queue and dec_ready=1 -> next cycle dec_valid=0, count=0, IDLE, fetch_pc=redirect target.
REQ-038 fetch_pc=16'hFFFE, fetch_stall raised while BUSY -> outstanding word pushed with dec_pc=FFFE, fetch_pc wraps to 0000, no further mem_req until fetch_stall=0.
REQ-039 mem_ack delayed 4 cycles -> mem_req and mem_addr held constant all 4 cycles; rst asserted in cycle 2 -> all outputs at reset values next cycle.
